prod_accum: RTL

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 118 +++++++++++
 1 files changed

// File: rtl/prod_accum.sv
// Sums ACC_LEN signed products per frame with per-add saturation; result valid 1 cycle after the last accept.
// prod_ready drops while a result waits in HOLD; clear aborts the frame at any time.
module prod_accum #(
    parameter int ACC_LEN = 8,
    parameter int OUT_W   = 24
) (
    input  logic                    clk100,
    input  logic                    reset,
    input  logic signed [15:0]      prod,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    input  logic                    clear,
    output logic signed [OUT_W-1:0] acc_sum,
    output logic                    acc_sat,
    output logic                    acc_valid,
    input  logic                    acc_ready
);

    localparam int CNT_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_q, state_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
    logic signed [OUT_W-1:0] sum_q, sum_d;
    logic                    sat_q, sat_d;

    logic                    accept;
    logic                    last_accept;
    logic signed [OUT_W:0]   wide_sum;
    logic                    ovf;
    logic signed [OUT_W-1:0] sat_val;

    assign accept      = prod_valid && prod_ready;
    assign last_accept = accept && (cnt_q == LAST_CNT);

    // One guard bit is enough to detect overflow of a single 16-bit add.
    assign wide_sum = {acc_q[OUT_W-1], acc_q} + {{(OUT_W+1-16){prod[15]}}, prod};
    assign ovf      = wide_sum[OUT_W] != wide_sum[OUT_W-1];
    assign sat_val  = ovf ? (wide_sum[OUT_W] ? MIN_V : MAX_V) : wide_sum[OUT_W-1:0];

    // State register
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over accept and handshake
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (last_accept) state_d = HOLD;
                HOLD:    if (acc_ready)   state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Outputs
    always_comb begin
        prod_ready = (state_q == ACCUM) && !reset;
        acc_valid  = (state_q == HOLD);
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        sum_d    = sum_q;
        sat_d    = sat_q;
        if (clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (last_accept) begin
            sum_d    = sat_val;
            sat_d    = sticky_q | ovf;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept) begin
            acc_d    = sat_val;
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | ovf;
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sum_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sum_q    <= sum_d;
            sat_q    <= sat_d;
        end
    end

    assign acc_sum = sum_q;
    assign acc_sat = sat_q;

endmodule
